// File: rtl/instr_mem_resp_pkg.sv
// Shared types and constants for the instruction-memory responder.
package instr_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam int          CNT_W     = 3;

endpackage

// File: rtl/instr_mem_resp_if.sv
// Fetch/program-load bus of the instruction-memory responder.
// Handshake: a request transfers on a rising edge where req_valid & req_ready are both high.
interface instr_mem_resp_if #(parameter int ADDR_W = 16);

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              flush;
    logic              resp_valid;
    logic [15:0]       resp_instr;
    logic [ADDR_W-1:0] resp_addr;
    logic              resp_err;
    logic              stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (
        output req_valid, req_addr, flush, wr_en, wr_addr, wr_data,
        input  req_ready, resp_valid, resp_instr, resp_addr, resp_err, stall
    );

    modport slave (
        input  req_valid, req_addr, flush, wr_en, wr_addr, wr_data,
        output req_ready, resp_valid, resp_instr, resp_addr, resp_err, stall
    );

endinterface

// File: rtl/imem_array.sv
// Word-organised instruction storage: synchronous write port, registered read port.
module imem_array #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read samples the pre-write contents, so a same-edge write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_mem_resp.sv
// Multi-cycle instruction-memory responder with flush and stall.
// Optional misaligned-fetch reporting is enabled by defining IMEM_ALIGN_CHECK_EN.
module instr_mem_resp
    import instr_mem_resp_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_mem_resp_if.slave  bus,
    output state_e           dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LOAD  = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;
    localparam state_e           ACC_STATE = (LATENCY == 1) ? RESP : WAIT;

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic [15:0]       rd_data;
    logic [ADDR_W-1:0] resp_addr_q;
    logic              unused_bits;

    assign bus.req_ready = (state == IDLE) | (state == RESP);
    assign accept        = bus.req_valid & bus.req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            resp_addr_q <= '0;
        end else begin
            if (accept) begin
                resp_addr_q <= bus.req_addr;
            end
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        state <= ACC_STATE;
                        cnt   <= CNT_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    imem_array #(.AW(ADDR_W - 1)) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr[ADDR_W-1:1]),
        .wr_data (bus.wr_data),
        .rd_en   (accept),
        .rd_addr (bus.req_addr[ADDR_W-1:1]),
        .rd_data (rd_data)
    );

    // A flush in the response cycle suppresses the pulse and is seen by fetch as a stall.
    assign bus.resp_valid = (state == RESP) & ~bus.flush;
    assign bus.stall      = (state == WAIT) | ((state == RESP) & bus.flush);
    assign bus.resp_addr  = resp_addr_q;
    assign dbg_state      = state;

`ifdef IMEM_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= bus.req_addr[0];
        end
    end

    assign bus.resp_err   = err_q;
    assign bus.resp_instr = err_q ? NOP_INSTR : rd_data;
`else
    assign bus.resp_err   = 1'b0;
    assign bus.resp_instr = rd_data;
`endif

    // Byte-offset bits never select a word.
    assign unused_bits = bus.req_addr[0] ^ bus.wr_addr[0];

endmodule

// File: tb/tb_instr_mem_resp.sv
// Bench for instr_mem_resp: three instances (LATENCY 1, 2, 3) share one random stimulus stream.
module tb_instr_mem_resp;
  import instr_mem_resp_pkg::*;

  localparam int AW = 16;
  localparam int NL = 3;

  typedef struct packed {
    logic [1:0]    lane;
    int            due;
    logic [AW-1:0] addr;
    logic [15:0]   instr;
    logic          err;
  } exp_t;

  exp_t exp_q[$];

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, flush, wr_en;
  logic [AW-1:0] req_addr, wr_addr;
  logic [15:0] wr_data;

  logic [NL-1:0] rv, rr, st, re;
  logic [NL-1:0][15:0] ri;
  logic [NL-1:0][AW-1:0] ra;
  logic [NL-1:0][1:0] dbg_bits;

  logic [15:0] mem_m [0:31];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // clock / reset
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    instr_mem_resp_if #(.ADDR_W(AW)) bus ();
    assign bus.req_valid = req_valid;
    assign bus.req_addr  = req_addr;
    assign bus.flush     = flush;
    assign bus.wr_en     = wr_en;
    assign bus.wr_addr   = wr_addr;
    assign bus.wr_data   = wr_data;
    assign rv[gi] = bus.resp_valid;
    assign rr[gi] = bus.req_ready;
    assign st[gi] = bus.stall;
    assign re[gi] = bus.resp_err;
    assign ri[gi] = bus.resp_instr;
    assign ra[gi] = bus.resp_addr;

    instr_mem_resp #(.ADDR_W(AW), .LATENCY(gi + 1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_bits[gi])
    );
  end

  task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lat%0d cyc%0d: got %h expected %h", name, l + 1, cyc, act, exp);
    end
  endtask

  function automatic int find_lane(input int l);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].lane == 2'(l)) return i;
    end
    return -1;
  endfunction

  // scoreboard: reference model and monitor, evaluated mid-cycle
  always @(negedge clk) begin
    int idx;
    logic busy, in_resp;
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      for (int l = 0; l < NL; l++) begin
        chk("rst_resp_valid", l, 32'(rv[l]), 32'd0);
        chk("rst_stall", l, 32'(st[l]), 32'd0);
        chk("rst_req_ready", l, 32'(rr[l]), 32'd1);
        chk("rst_resp_instr", l, 32'(ri[l]), 32'h0000);
        chk("rst_resp_addr", l, 32'(ra[l]), 32'h0000);
        chk("rst_resp_err", l, 32'(re[l]), 32'd0);
        chk("rst_state", l, 32'(dbg_bits[l]), 32'(IDLE));
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        idx = find_lane(l);
        busy = (idx >= 0);
        in_resp = busy && (exp_q[idx].due == cyc);
        chk("req_ready", l, 32'(rr[l]), 32'(!busy || in_resp));
        chk("stall", l, 32'(st[l]), 32'(busy && (!in_resp || flush)));
        chk("resp_valid", l, 32'(rv[l]), 32'(in_resp && !flush));
        if (in_resp && !flush && rv[l]) begin
          chk("resp_addr", l, 32'(ra[l]), 32'(exp_q[idx].addr));
          chk("resp_instr", l, 32'(ri[l]), 32'(exp_q[idx].instr));
          chk("resp_err", l, 32'(re[l]), 32'(exp_q[idx].err));
        end
        // response delivered, dropped by flush, or cancelled while waiting
        if (busy && (in_resp || flush)) exp_q.delete(idx);
        if (req_valid && (!busy || in_resp)) begin
          e.lane = 2'(l);
          e.due  = cyc + l + 1;
          e.addr = req_addr;
`ifdef IMEM_ALIGN_CHECK_EN
          e.instr = req_addr[0] ? NOP_INSTR : mem_m[req_addr[5:1]];
          e.err   = req_addr[0];
`else
          e.instr = mem_m[req_addr[5:1]];
          e.err   = 1'b0;
`endif
          exp_q.push_back(e);
        end
      end
    end
    if (wr_en) mem_m[wr_addr[5:1]] = wr_data;
    cyc++;
  end

  // driver tasks
  task automatic drive(input logic v, input logic [AW-1:0] a, input logic f);
    req_valid = v;
    req_addr  = a;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_addr = 16'(i * 2);
      wr_data = (i == 2) ? 16'hA5C3 : 16'($urandom);
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // basic read of the preloaded word
    drive(1'b1, 16'h0004, 1'b0); idle(5);
    // back-to-back requests
    drive(1'b1, 16'h0000, 1'b0); drive(1'b1, 16'h0002, 1'b0); drive(1'b1, 16'h0004, 1'b0); idle(5);
    // redirect while waiting
    drive(1'b1, 16'h0010, 1'b0); drive(1'b1, 16'h0020, 1'b1); drive(1'b1, 16'h0020, 1'b0); idle(5);
    // flush during the response cycle of the LATENCY=2 instance
    drive(1'b1, 16'h0008, 1'b0); idle(1); drive(1'b0, '0, 1'b1); idle(5);
    // misaligned fetch
    drive(1'b1, 16'h0003, 1'b0); idle(5);
    // reset while requests are outstanding
    drive(1'b1, 16'h0006, 1'b0); req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 16'h0006, 1'b0); idle(5);

    // random traffic with writes, flushes and occasional resets
    for (int i = 0; i < 800; i++) begin
      wr_en   = ($urandom_range(0, 4) == 0);
      wr_addr = 16'($urandom_range(0, 63));
      wr_data = 16'($urandom);
      rst_n   = ($urandom_range(0, 149) != 0);
      drive($urandom_range(0, 9) < 7, 16'($urandom_range(0, 63)), $urandom_range(0, 9) == 0);
    end
    rst_n = 1'b1;
    wr_en = 1'b0;
    idle(8);
    chk("drain", 0, 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
